// File: rtl/fetch_unit.sv
// Purpose: holds the PC, fetches one instruction per imem handshake, issues it to decode, applies pc_sel.
// Latency: 1 cycle from imem_ack edge to instr_valid; best case 2 cycles per instruction.
// Backpressure: stalls in FETCH until imem_ack and in ISSUE until issue_ack; one instruction outstanding.
module fetch_unit #(
    parameter int          AW       = 8,
    parameter int          IW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] imem_addr,
    output logic          imem_req,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_data,
    output logic [IW-1:0] instr,
    output logic [4:0]    opcode,
    output logic          instr_valid,
    input  logic          issue_ack,
    input  logic [2:0]    pc_sel,
    input  logic          zero,
    input  logic [AW-1:0] rs_val,
    output logic [AW-1:0] pc,
    output logic          halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] instr_q, instr_d;

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_br;
    logic [AW-1:0] next_pc;

    // Next-PC selection; all arithmetic wraps modulo 2^AW, offset is sign-extended instr[7:0]
    always_comb begin
        pc_inc  = pc_q + AW'(1);
        pc_br   = pc_inc + AW'($signed(instr_q[7:0]));
        next_pc = pc_inc;
        case (pc_sel)
            3'b000:  next_pc = pc_inc;
            3'b001:  next_pc = zero ? pc_br : pc_inc;
            3'b010:  next_pc = zero ? pc_inc : pc_br;
            3'b011:  next_pc = instr_q[AW-1:0];
            3'b100:  next_pc = rs_val;
            default: next_pc = pc_inc;   // 101 never commits a PC; 110/111 reserved as sequential
        endcase
    end

    // State transitions and datapath capture; handshakes are only honoured in their own state
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_ack) begin
                    if (pc_sel == 3'b101) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // State, PC and instruction registers; reset takes effect immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Handshake/status outputs decode registered state only
    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == ISSUE);
    assign halted      = (state_q == HALT);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[IW-1:IW-5];

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: self-checking bench for fetch_unit against a behavioural next-PC model.
// Latency: samples 1 time unit after each rising edge; drives inputs at the same point.
// Backpressure: randomized imem_ack / issue_ack stall lengths, spurious acks outside their states.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic [4:0]  opcode;
    logic        instr_valid;
    logic        issue_ack;
    logic [2:0]  pc_sel;
    logic        zero;
    logic [7:0]  rs_val;
    logic [7:0]  pc;
    logic        halted;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [7:0] exp_pc;

    always #5 clk = ~clk;

    fetch_unit #(.AW(8), .IW(16), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .issue_ack(issue_ack),
        .pc_sel(pc_sel), .zero(zero), .rs_val(rs_val), .pc(pc), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: next PC from the architectural rules using plain integer arithmetic
    function automatic logic [7:0] model_next(input logic [7:0] cur, input logic [15:0] word,
                                              input logic [2:0] sel, input logic z,
                                              input logic [7:0] rs);
        int off;
        int r;
        off = (word[7] == 1'b1) ? int'(word[7:0]) - 256 : int'(word[7:0]);
        case (sel)
            3'd0: r = int'(cur) + 1;
            3'd1: r = z ? int'(cur) + 1 + off : int'(cur) + 1;
            3'd2: r = z ? int'(cur) + 1 : int'(cur) + 1 + off;
            3'd3: r = int'(word[7:0]);
            3'd4: r = int'(rs);
            3'd5: r = int'(cur);
            default: r = int'(cur) + 1;
        endcase
        r = ((r % 256) + 256) % 256;
        return r[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full instruction: fetch with fdly stall cycles, issue with idly stall cycles
    task automatic run_instr(input logic [15:0] word, input int fdly, input int idly,
                             input logic [2:0] sel, input logic z, input logic [7:0] rs);
        logic [7:0] nxt;
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
        imem_ack = 1'b0;
        for (int i = 0; i < fdly; i++) begin
            issue_ack = 1'($urandom);
            imem_data = 16'($urandom);
            step();
            chk("stall_req", {31'd0, imem_req}, 32'd1);
            chk("stall_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
        end
        issue_ack = 1'b0;
        imem_data = word;
        imem_ack  = 1'b1;
        step();
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        chk("issue_valid", {31'd0, instr_valid}, 32'd1);
        chk("issue_instr", {16'd0, instr}, {16'd0, word});
        chk("issue_opcode", {27'd0, opcode}, {27'd0, word[15:11]});
        chk("issue_req_low", {31'd0, imem_req}, 32'd0);
        pc_sel = sel;
        zero   = z;
        rs_val = rs;
        for (int i = 0; i < idly; i++) begin
            imem_ack = 1'($urandom);
            step();
            chk("hold_valid", {31'd0, instr_valid}, 32'd1);
            chk("hold_opcode", {27'd0, opcode}, {27'd0, word[15:11]});
            chk("hold_pc", {24'd0, pc}, {24'd0, exp_pc});
        end
        nxt = model_next(exp_pc, word, sel, z, rs);
        imem_ack  = 1'b0;
        issue_ack = 1'b1;
        step();
        issue_ack = 1'b0;
        pc_sel    = 3'($urandom);
        zero      = 1'($urandom);
        rs_val    = 8'($urandom);
        exp_pc    = nxt;
        chk("next_pc", {24'd0, pc}, {24'd0, exp_pc});
        if (sel == 3'b101) begin
            chk("halt_flag", {31'd0, halted}, 32'd1);
            chk("halt_req", {31'd0, imem_req}, 32'd0);
        end else begin
            chk("refetch_req", {31'd0, imem_req}, 32'd1);
        end
    endtask

    initial begin
        logic [2:0] rsel;
        rst = 1'b1; imem_ack = 1'b0; imem_data = '0; issue_ack = 1'b0;
        pc_sel = '0; zero = 1'b0; rs_val = '0;
        exp_pc = 8'h00;
        step();
        step();
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_instr", {16'd0, instr}, 32'd0);
        chk("rst_opcode", {27'd0, opcode}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        step();

        // Sequential stepping, zero-delay handshakes
        for (int i = 0; i < 4; i++) run_instr(16'h0000, 0, 0, 3'b000, 1'b0, 8'h00);
        // Wrap at the top of the address space
        run_instr(16'h18FE, 0, 0, 3'b011, 1'b0, 8'h00);
        run_instr(16'h0000, 0, 0, 3'b000, 1'b0, 8'h00);
        run_instr(16'h0000, 0, 0, 3'b000, 1'b0, 8'h00);
        chk("wrap_zero", {24'd0, pc}, 32'd0);
        // Stalls
        run_instr(16'hA123, 3, 4, 3'b000, 1'b0, 8'h00);
        // Branches at pc 0x10
        run_instr(16'h0010, 0, 0, 3'b011, 1'b0, 8'h00);
        run_instr(16'h08FC, 1, 1, 3'b001, 1'b1, 8'h00);
        chk("br_taken", {24'd0, pc}, 32'h0D);
        run_instr(16'h0010, 0, 0, 3'b011, 1'b0, 8'h00);
        run_instr(16'h08FC, 0, 2, 3'b001, 1'b0, 8'h00);
        chk("br_not_taken", {24'd0, pc}, 32'h11);
        run_instr(16'h0010, 0, 0, 3'b011, 1'b0, 8'h00);
        run_instr(16'h1005, 2, 0, 3'b010, 1'b0, 8'h00);
        chk("bnz_taken", {24'd0, pc}, 32'h16);
        // Jumps
        run_instr(16'h1842, 0, 0, 3'b011, 1'b1, 8'h00);
        chk("jump_tgt", {24'd0, pc}, 32'h42);
        run_instr(16'h2000, 0, 0, 3'b100, 1'b0, 8'h99);
        chk("jump_reg", {24'd0, pc}, 32'h99);
        run_instr(16'h3077, 0, 0, 3'b110, 1'b1, 8'h00);
        chk("reserved_seq", {24'd0, pc}, 32'h9A);
        // Randomized instructions (no halt)
        for (int i = 0; i < 30; i++) begin
            rsel = 3'($urandom_range(0, 6));
            if (rsel == 3'b101) rsel = 3'b111;
            run_instr(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), rsel,
                      1'($urandom), 8'($urandom));
        end
        // Halt at pc 0x07
        run_instr(16'h0007, 0, 0, 3'b011, 1'b0, 8'h00);
        run_instr(16'hF800, 0, 0, 3'b101, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            imem_ack  = 1'($urandom);
            issue_ack = 1'($urandom);
            step();
            chk("halt_hold_req", {31'd0, imem_req}, 32'd0);
            chk("halt_hold_pc", {24'd0, pc}, 32'h07);
            chk("halt_hold_flag", {31'd0, halted}, 32'd1);
        end
        imem_ack = 1'b0; issue_ack = 1'b0;

        // Leave halt via reset, then reach ISSUE at pc 0x30
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_pc = 8'h00;
        chk("unhalt_flag", {31'd0, halted}, 32'd0);
        step();
        run_instr(16'h0030, 0, 0, 3'b011, 1'b0, 8'h00);
        imem_data = 16'hC0DE;
        imem_ack  = 1'b1;
        step();
        imem_ack  = 1'b0;
        chk("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        chk("pre_rst_pc", {24'd0, pc}, 32'h30);
        #2;
        rst       = 1'b1;
        issue_ack = 1'b1;
        pc_sel    = 3'b011;
        #1;
        chk("async_pc", {24'd0, pc}, 32'd0);
        chk("async_valid", {31'd0, instr_valid}, 32'd0);
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_instr", {16'd0, instr}, 32'd0);
        step();
        chk("rst_ack_ignored", {24'd0, pc}, 32'd0);
        issue_ack = 1'b0;
        rst = 1'b0;
        step();
        exp_pc = 8'h00;
        run_instr(16'h0000, 1, 1, 3'b000, 1'b0, 8'h00);
        chk("restart_pc", {24'd0, pc}, 32'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
